// File: rtl/dmaarbiter.sv
// Zorro III bus-ownership arbiter for the NCR 53C710 DMA path: turns BR/BG/BGACK into Z_BR_n/Z_BG_n
// ownership and drives mybus/MASTER_n. Define ARB_TIMEOUT_EN to enable the grant timeout and BACKOFF state.
module dmaarbiter #(
   parameter int GRANT_TIMEOUT  = 255,
   parameter int BACKOFF_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic bclk,
   input  logic IORST,
   input  logic SCSI_BR_n,
   input  logic SCSI_BGACK_n,
   input  logic SCSI_AS_n,
   input  logic Z_BG_n,
   input  logic Z_FCS_n,
   input  logic DTACK_n,
   input  logic SLAVE_n,
   output logic SCSI_BG_n,
   output logic Z_BR_n,
   output logic mybus,
   output logic MASTER_n,
   output logic arb_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_IDLE,
      S_OWN,
      S_ACTIVE,
      S_RELEASE
`ifdef ARB_TIMEOUT_EN
      , S_BACKOFF
`endif
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX =
      CNT_W'((GRANT_TIMEOUT > BACKOFF_CYCLES) ? GRANT_TIMEOUT : BACKOFF_CYCLES);
`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] GRANT_LAST   = CNT_W'(GRANT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);
`endif

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cnt_inc;
   logic [3:0]       async_p0, async_p1;
   logic             bg_s, busfree_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Stage p0/p1: two-flop synchronisers for the asynchronous Zorro inputs
   always_ff @(posedge bclk) begin
      async_p0 <= {Z_BG_n, Z_FCS_n, DTACK_n, SLAVE_n};
      async_p1 <= async_p0;
   end

   assign bg_s      = async_p1[3];
   assign busfree_s = &async_p1[2:0];

   always_comb begin
      state_nxt = state;
      cnt_inc   = 1'b0;
      case (state)
         S_IDLE:
            if (!SCSI_BR_n) state_nxt = S_REQ;
         S_REQ: begin
            cnt_inc = 1'b1;
            if (SCSI_BR_n)  state_nxt = S_IDLE;
            else if (!bg_s) state_nxt = S_WAIT_IDLE;
`ifdef ARB_TIMEOUT_EN
            else if (cnt == GRANT_LAST) state_nxt = S_BACKOFF;
`endif
         end
         S_WAIT_IDLE: begin
            // cnt holds the number of preceding consecutive free-bus cycles
            cnt_inc = busfree_s;
            if (SCSI_BR_n)                       state_nxt = S_IDLE;
            else if (bg_s)                       state_nxt = S_REQ;
            else if (busfree_s && (cnt != '0))   state_nxt = S_OWN;
         end
         S_OWN:
            if (!SCSI_BGACK_n)  state_nxt = S_ACTIVE;
            else if (SCSI_BR_n) state_nxt = S_RELEASE;
         S_ACTIVE:
            if (SCSI_BGACK_n && SCSI_AS_n) state_nxt = S_RELEASE;
         S_RELEASE:
            state_nxt = S_IDLE;
`ifdef ARB_TIMEOUT_EN
         S_BACKOFF: begin
            cnt_inc = 1'b1;
            if (cnt == BACKOFF_LAST) state_nxt = SCSI_BR_n ? S_IDLE : S_REQ;
         end
`endif
         default:
            state_nxt = S_IDLE;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
      else if (cnt_inc)       cnt_nxt = sat_inc(cnt);
      else                    cnt_nxt = '0;
   end

   // Outputs are registered from the next state so they line up with the state register
   always_ff @(posedge bclk) begin
      if (IORST) begin
         state     <= S_IDLE;
         cnt       <= '0;
         SCSI_BG_n <= 1'b1;
         Z_BR_n    <= 1'b1;
         mybus     <= 1'b0;
         MASTER_n  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
         arb_timeout <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         SCSI_BG_n <= (state_nxt != S_OWN);
         Z_BR_n    <= !((state_nxt == S_REQ) || (state_nxt == S_WAIT_IDLE) ||
                        (state_nxt == S_OWN) || (state_nxt == S_ACTIVE));
         mybus     <= (state_nxt == S_OWN) || (state_nxt == S_ACTIVE) || (state_nxt == S_RELEASE);
         MASTER_n  <= !((state_nxt == S_OWN) || (state_nxt == S_ACTIVE));
`ifdef ARB_TIMEOUT_EN
         arb_timeout <= (state_nxt == S_BACKOFF) && (state != S_BACKOFF);
`endif
      end
   end

`ifndef ARB_TIMEOUT_EN
   assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dmaarbiter.sv
// Directed self-checking bench for dmaarbiter; output bundle o = {SCSI_BG_n, Z_BR_n, mybus, MASTER_n}.
module tb_dmaarbiter;

   logic bclk = 1'b0;
   logic IORST = 1'b1;
   logic SCSI_BR_n = 1'b1, SCSI_BGACK_n = 1'b1, SCSI_AS_n = 1'b1;
   logic Z_BG_n = 1'b1, Z_FCS_n = 1'b1, DTACK_n = 1'b1, SLAVE_n = 1'b1;
   logic SCSI_BG_n, Z_BR_n, mybus, MASTER_n, arb_timeout;
   logic [3:0] o;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [3:0] O_IDLE    = 4'b1101;
   localparam logic [3:0] O_REQ     = 4'b1001;
   localparam logic [3:0] O_OWN     = 4'b0010;
   localparam logic [3:0] O_ACTIVE  = 4'b1010;
   localparam logic [3:0] O_RELEASE = 4'b1111;

   assign o = {SCSI_BG_n, Z_BR_n, mybus, MASTER_n};

   always #5 bclk = ~bclk;

   dmaarbiter dut (
      .bclk(bclk), .IORST(IORST),
      .SCSI_BR_n(SCSI_BR_n), .SCSI_BGACK_n(SCSI_BGACK_n), .SCSI_AS_n(SCSI_AS_n),
      .Z_BG_n(Z_BG_n), .Z_FCS_n(Z_FCS_n), .DTACK_n(DTACK_n), .SLAVE_n(SLAVE_n),
      .SCSI_BG_n(SCSI_BG_n), .Z_BR_n(Z_BR_n), .mybus(mybus), .MASTER_n(MASTER_n),
      .arb_timeout(arb_timeout)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge bclk);
         #1;
      end
   endtask

   task automatic test_reset();
      tick(3);
      n_cmp++; if ({o, arb_timeout} !== {O_IDLE, 1'b0}) begin n_bad++; $display("FAIL reset_outs: got %b want %b", {o, arb_timeout}, {O_IDLE, 1'b0}); end
      SCSI_BR_n = 1'b0;
      tick();
      n_cmp++; if (o !== O_IDLE) begin n_bad++; $display("FAIL reset_holds: got %b want %b", o, O_IDLE); end
      SCSI_BR_n = 1'b1;
      IORST = 1'b0;
      tick();
      n_cmp++; if (o !== O_IDLE) begin n_bad++; $display("FAIL reset_idle: got %b want %b", o, O_IDLE); end
   endtask

   task automatic test_basic_tenure();
      SCSI_BR_n = 1'b0;
      tick();
      n_cmp++; if (o !== O_REQ) begin n_bad++; $display("FAIL basic_req: got %b want %b", o, O_REQ); end
      tick(4);
      Z_BG_n = 1'b0;
      tick(4);
      n_cmp++; if (o !== O_REQ) begin n_bad++; $display("FAIL basic_wait: got %b want %b", o, O_REQ); end
      tick();
      n_cmp++; if (o !== O_OWN) begin n_bad++; $display("FAIL basic_own: got %b want %b", o, O_OWN); end
      tick();
      n_cmp++; if (o !== O_OWN) begin n_bad++; $display("FAIL basic_own2: got %b want %b", o, O_OWN); end
      SCSI_BGACK_n = 1'b0;
      SCSI_BR_n = 1'b1;
      tick();
      n_cmp++; if (o !== O_ACTIVE) begin n_bad++; $display("FAIL basic_active: got %b want %b", o, O_ACTIVE); end
      for (int i = 0; i < 3; i++) begin
         SCSI_AS_n = 1'b0;
         tick();
         n_cmp++; if (o !== O_ACTIVE) begin n_bad++; $display("FAIL basic_as_low%0d: got %b want %b", i, o, O_ACTIVE); end
         SCSI_AS_n = 1'b1;
         tick();
         n_cmp++; if (o !== O_ACTIVE) begin n_bad++; $display("FAIL basic_as_high%0d: got %b want %b", i, o, O_ACTIVE); end
      end
      SCSI_AS_n = 1'b0;
      SCSI_BGACK_n = 1'b1;
      tick();
      n_cmp++; if (o !== O_ACTIVE) begin n_bad++; $display("FAIL basic_as_hold: got %b want %b", o, O_ACTIVE); end
      SCSI_AS_n = 1'b1;
      Z_BG_n = 1'b1;
      tick();
      n_cmp++; if (o !== O_RELEASE) begin n_bad++; $display("FAIL basic_release: got %b want %b", o, O_RELEASE); end
      SCSI_BR_n = 1'b0;
      tick();
      n_cmp++; if (o !== O_IDLE) begin n_bad++; $display("FAIL basic_release_ignores_br: got %b want %b", o, O_IDLE); end
      tick();
      n_cmp++; if (o !== O_REQ) begin n_bad++; $display("FAIL basic_rereq: got %b want %b", o, O_REQ); end
      SCSI_BR_n = 1'b1;
      tick();
      n_cmp++; if (o !== O_IDLE) begin n_bad++; $display("FAIL basic_req_withdraw: got %b want %b", o, O_IDLE); end
   endtask

   task automatic test_busy_bus();
      Z_FCS_n = 1'b0;
      Z_BG_n = 1'b0;
      SCSI_BR_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++; if (o !== O_REQ) begin n_bad++; $display("FAIL busy_wait%0d: got %b want %b", i, o, O_REQ); end
      end
      Z_FCS_n = 1'b1;
      tick(3);
      n_cmp++; if (o !== O_REQ) begin n_bad++; $display("FAIL busy_not_yet: got %b want %b", o, O_REQ); end
      tick();
      n_cmp++; if (o !== O_OWN) begin n_bad++; $display("FAIL busy_own: got %b want %b", o, O_OWN); end
   endtask

   task automatic test_withdraw();
      SCSI_BR_n = 1'b1;
      Z_BG_n = 1'b1;
      tick();
      n_cmp++; if (o !== O_RELEASE) begin n_bad++; $display("FAIL withdraw_release: got %b want %b", o, O_RELEASE); end
      tick();
      n_cmp++; if (o !== O_IDLE) begin n_bad++; $display("FAIL withdraw_idle: got %b want %b", o, O_IDLE); end
   endtask

   task automatic test_reset_active();
      Z_BG_n = 1'b0;
      SCSI_BR_n = 1'b0;
      tick(5);
      n_cmp++; if (o !== O_OWN) begin n_bad++; $display("FAIL rst_own: got %b want %b", o, O_OWN); end
      SCSI_BGACK_n = 1'b0;
      SCSI_AS_n = 1'b0;
      tick();
      n_cmp++; if (o !== O_ACTIVE) begin n_bad++; $display("FAIL rst_active: got %b want %b", o, O_ACTIVE); end
      IORST = 1'b1;
      tick();
      n_cmp++; if (o !== O_IDLE) begin n_bad++; $display("FAIL rst_mid_active: got %b want %b", o, O_IDLE); end
      IORST = 1'b0;
      SCSI_BGACK_n = 1'b1;
      SCSI_AS_n = 1'b1;
      SCSI_BR_n = 1'b1;
      Z_BG_n = 1'b1;
      tick();
      n_cmp++; if (o !== O_IDLE) begin n_bad++; $display("FAIL rst_after: got %b want %b", o, O_IDLE); end
      SCSI_BR_n = 1'b0;
      tick();
      n_cmp++; if (o !== O_REQ) begin n_bad++; $display("FAIL rst_from_idle: got %b want %b", o, O_REQ); end
      SCSI_BR_n = 1'b1;
      tick();
      n_cmp++; if (o !== O_IDLE) begin n_bad++; $display("FAIL rst_back_idle: got %b want %b", o, O_IDLE); end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      SCSI_BR_n = 1'b0;
      for (int i = 1; i <= 255; i++) begin
         tick();
         n_cmp++; if ({o, arb_timeout} !== {O_REQ, 1'b0}) begin n_bad++; $display("FAIL to_req%0d: got %b want %b", i, {o, arb_timeout}, {O_REQ, 1'b0}); end
      end
      tick();
      n_cmp++; if ({o, arb_timeout} !== {O_IDLE, 1'b1}) begin n_bad++; $display("FAIL to_pulse: got %b want %b", {o, arb_timeout}, {O_IDLE, 1'b1}); end
      for (int i = 1; i < 16; i++) begin
         tick();
         n_cmp++; if ({o, arb_timeout} !== {O_IDLE, 1'b0}) begin n_bad++; $display("FAIL to_backoff%0d: got %b want %b", i, {o, arb_timeout}, {O_IDLE, 1'b0}); end
      end
      tick();
      n_cmp++; if ({o, arb_timeout} !== {O_REQ, 1'b0}) begin n_bad++; $display("FAIL to_retry: got %b want %b", {o, arb_timeout}, {O_REQ, 1'b0}); end
      SCSI_BR_n = 1'b1;
      tick();
      n_cmp++; if (o !== O_IDLE) begin n_bad++; $display("FAIL to_idle: got %b want %b", o, O_IDLE); end
   endtask
`else
   task automatic test_no_timeout();
      SCSI_BR_n = 1'b0;
      for (int i = 1; i <= 1000; i++) begin
         tick();
         n_cmp++; if ({Z_BR_n, arb_timeout} !== 2'b00) begin n_bad++; $display("FAIL noto_cycle%0d: got %b want %b", i, {Z_BR_n, arb_timeout}, 2'b00); end
      end
      SCSI_BR_n = 1'b1;
      tick();
      n_cmp++; if (o !== O_IDLE) begin n_bad++; $display("FAIL noto_idle: got %b want %b", o, O_IDLE); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_tenure();
      test_busy_bus();
      test_withdraw();
      test_reset_active();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
